// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the Execute stage.
// Radix-2 shift-add multiply and restoring divide; one bit per cycle, with a stall until done.
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_E,
    input  logic [2:0]       op_E,
    input  logic [WIDTH-1:0] src_a_E,
    input  logic [WIDTH-1:0] src_b_E,
    input  logic [4:0]       rd_E,
    input  logic             flush,
    output logic             stall_req,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       rd_out
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state, state_next;
    logic [CNT_W-1:0]     count;
    logic [2:0]           op_q;
    logic [4:0]           rd_q;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic                 neg_q, neg_r;
    logic [2*WIDTH-1:0]   acc;

    logic                 is_div_E, a_signed_E, b_signed_E, a_neg_E, b_neg_E;
    logic [WIDTH-1:0]     a_abs_E, b_abs_E;
    logic                 div_zero_E, overflow_E, special_E;
    logic [WIDTH-1:0]     special_res;

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       rem_shift, rem_diff;
    logic                 rem_ge;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   acc_next;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix, rem_fix, calc_res;

    logic                 load_op, iterate, load_res, done_next;
    logic [WIDTH-1:0]     res_next;
    logic [4:0]           rd_next;

    // Operand decode on the Execute-register values
    always_comb begin
        is_div_E   = op_E[2];
        a_signed_E = (op_E == OP_MULH) || (op_E == OP_MULHSU) ||
                     (op_E == OP_DIV)  || (op_E == OP_REM);
        b_signed_E = (op_E == OP_MULH) || (op_E == OP_DIV) || (op_E == OP_REM);
        a_neg_E    = a_signed_E & src_a_E[WIDTH-1];
        b_neg_E    = b_signed_E & src_b_E[WIDTH-1];
        a_abs_E    = a_neg_E ? (~src_a_E + 1'b1) : src_a_E;
        b_abs_E    = b_neg_E ? (~src_b_E + 1'b1) : src_b_E;
        div_zero_E = is_div_E && (src_b_E == '0);
        overflow_E = ((op_E == OP_DIV) || (op_E == OP_REM)) &&
                     (src_a_E == MIN_NEG) && (src_b_E == ALL_ONES);
        special_E  = div_zero_E || overflow_E;
        special_res = '0;
        case (op_E)
            OP_DIV, OP_DIVU: special_res = div_zero_E ? ALL_ONES : MIN_NEG;
            OP_REM, OP_REMU: special_res = div_zero_E ? src_a_E : '0;
            default:         special_res = '0;
        endcase
    end

    // One iteration of the datapath; the final one feeds result selection directly
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_mag} : '0);
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, b_mag};
        rem_ge    = ~rem_diff[WIDTH];
        div_next  = {(rem_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0]),
                     acc[WIDTH-2:0], rem_ge};
        acc_next  = op_q[2] ? div_next : mul_next;

        prod_fix  = neg_q ? (~acc_next + 1'b1) : acc_next;
        quot_fix  = neg_q ? (~acc_next[WIDTH-1:0] + 1'b1) : acc_next[WIDTH-1:0];
        rem_fix   = neg_r ? (~acc_next[2*WIDTH-1:WIDTH] + 1'b1) : acc_next[2*WIDTH-1:WIDTH];
        case (op_q)
            OP_MUL:                       calc_res = prod_fix[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: calc_res = prod_fix[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:              calc_res = quot_fix;
            default:                      calc_res = rem_fix;
        endcase
    end

    always_comb begin
        state_next = state;
        load_op    = 1'b0;
        iterate    = 1'b0;
        load_res   = 1'b0;
        done_next  = 1'b0;
        res_next   = '0;
        rd_next    = '0;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start_E) begin
                        load_op = 1'b1;
                        if (special_E) begin
                            state_next = DONE;
                            load_res   = 1'b1;
                            done_next  = 1'b1;
                            res_next   = special_res;
                            rd_next    = rd_E;
                        end else begin
                            state_next = CALC;
                        end
                    end
                end
                CALC: begin
                    iterate = 1'b1;
                    if (count == LAST_CNT) begin
                        state_next = DONE;
                        load_res   = 1'b1;
                        done_next  = 1'b1;
                        res_next   = calc_res;
                        rd_next    = rd_q;
                    end
                end
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    assign stall_req = ((state == IDLE) && start_E && !flush) || (state == CALC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            op_q   <= '0;
            rd_q   <= '0;
            a_mag  <= '0;
            b_mag  <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            acc    <= '0;
            done   <= 1'b0;
            result <= '0;
            rd_out <= '0;
        end else begin
            state <= state_next;
            done  <= done_next;
            if (load_op) begin
                count <= '0;
                op_q  <= op_E;
                rd_q  <= rd_E;
                a_mag <= a_abs_E;
                b_mag <= b_abs_E;
                neg_q <= a_neg_E ^ b_neg_E;
                neg_r <= a_neg_E;
                acc   <= {{WIDTH{1'b0}}, (is_div_E ? a_abs_E : b_abs_E)};
            end else if (iterate) begin
                count <= count + 1'b1;
                acc   <= acc_next;
            end
            if (load_res) begin
                result <= res_next;
                rd_out <= rd_next;
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: expected results queued at issue, compared at done.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_E;
    logic [2:0]  op_E;
    logic [31:0] src_a_E, src_b_E;
    logic [4:0]  rd_E;
    logic        flush;
    logic        stall_req, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] exp_res_q[$];
    logic [4:0]  exp_rd_q[$];
    int          exp_lat_q[$];

    ex_muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start_E(start_E), .op_E(op_E),
        .src_a_E(src_a_E), .src_b_E(src_b_E), .rd_E(rd_E), .flush(flush),
        .stall_req(stall_req), .done(done), .result(result), .rd_out(rd_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sp;
        logic [63:0] ua, ub, up;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            3'd0: begin up = ua * ub; return up[31:0]; end
            3'd1: begin sp = sa * sb; return sp[63:32]; end
            3'd2: begin sp = sa * $signed(ub); return sp[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                sp = sa / sb; return sp[31:0];
            end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                sp = sa % sb; return sp[31:0];
            end
            default: begin if (b == 0) return a; return a % b; end
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Called right after a rising edge; returns right after the edge that ends the done cycle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input int exp_lat,
                          output int done_cyc);
        int stalls;
        bit got;
        logic [31:0] er;
        logic [4:0] erd;
        int elat;
        start_E = 1'b1; op_E = op; src_a_E = a; src_b_E = b; rd_E = rd;
        exp_res_q.push_back(exp);
        exp_rd_q.push_back(rd);
        exp_lat_q.push_back(exp_lat);
        stalls = 0; got = 0; done_cyc = -1;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                done_cyc = cyc;
                er = exp_res_q.pop_front();
                erd = exp_rd_q.pop_front();
                elat = exp_lat_q.pop_front();
                checks += 4;
                if (result !== er) begin
                    errors++; $display("FAIL result op=%0d a=%h b=%h: got %h expected %h", op, a, b, result, er);
                end
                if (rd_out !== erd) begin
                    errors++; $display("FAIL rd_out op=%0d: got %0d expected %0d", op, rd_out, erd);
                end
                if (c != elat || stalls != elat) begin
                    errors++; $display("FAIL latency op=%0d: done cycle %0d stalls %0d expected %0d", op, c, stalls, elat);
                end
                if (stall_req !== 1'b0) begin
                    errors++; $display("FAIL stall_in_done op=%0d: got %b expected 0", op, stall_req);
                end
            end else if (stall_req) begin
                stalls++;
            end
            @(posedge clk); #1;
        end
        start_E = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL timeout op=%0d: no done within 100 cycles, expected done at %0d", op, exp_lat);
            void'(exp_res_q.pop_front()); void'(exp_rd_q.pop_front()); void'(exp_lat_q.pop_front());
        end
    endtask

    task automatic check_done_low(input string name);
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL %s: done got %b expected 0", name, done);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; start_E = 0; op_E = 0; src_a_E = 0; src_b_E = 0; rd_E = 0; flush = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (done !== 1'b0 || result !== 32'd0 || rd_out !== 5'd0 || stall_req !== 1'b0) begin
            errors++;
            $display("FAIL reset: done=%b result=%h rd_out=%0d stall=%b expected all 0", done, result, rd_out, stall_req);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mul;
        int d;
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 33, d);
        check_done_low("done_one_cycle");
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, 33, d);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, 33, d);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd8, 32'hFFFF_FFFF, 33, d);
    endtask

    task automatic test_div;
        int d;
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFD, 33, d);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF, 33, d);
        run_op(3'd5, 32'd100, 32'd7, 5'd11, 32'd14, 33, d);
    endtask

    task automatic test_special;
        int d;
        run_op(3'd5, 32'h1234, 32'd0, 5'd12, 32'hFFFF_FFFF, 1, d);
        run_op(3'd7, 32'h1234, 32'd0, 5'd13, 32'h1234, 1, d);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1, d);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0, 1, d);
        check_done_low("special_done_one_cycle");
    endtask

    task automatic test_flush;
        int d;
        int seen;
        logic [31:0] prev;
        run_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3, model(3'd1, 32'h1234_5678, 32'h9ABC_DEF0), 33, d);
        prev = result;
        start_E = 1'b1; op_E = 3'd4; src_a_E = 32'd1000; src_b_E = 32'd3; rd_E = 5'd20;
        @(posedge clk); #1;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1; start_E = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        checks += 2;
        if (stall_req !== 1'b0) begin
            errors++; $display("FAIL flush_stall: got %b expected 0", stall_req);
        end
        if (result !== prev) begin
            errors++; $display("FAIL flush_result: got %h expected %h", result, prev);
        end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL flush_no_done: done seen %0d times expected 0", seen);
        end
        @(posedge clk); #1;
        run_op(3'd0, 32'd123, 32'd456, 5'd21, 32'd56088, 33, d);
    endtask

    task automatic test_back_to_back;
        int d1, d2;
        run_op(3'd0, 32'hDEAD_BEEF, 32'd3, 5'd1, model(3'd0, 32'hDEAD_BEEF, 32'd3), 33, d1);
        run_op(3'd4, 32'hFFFF_FC18, 32'd7, 5'd2, model(3'd4, 32'hFFFF_FC18, 32'd7), 33, d2);
        checks++;
        if (d2 - d1 != 34) begin
            errors++; $display("FAIL back_to_back_spacing: got %0d cycles expected 34", d2 - d1);
        end
    endtask

    task automatic test_random;
        int d;
        logic [2:0] op;
        logic [31:0] a, b;
        for (int i = 0; i < 16; i++) begin
            op = 3'($urandom_range(0, 7));
            a = $urandom();
            b = (i % 5 == 4) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom());
            run_op(op, a, b, 5'(i + 1), model(op, a, b), model_lat(op, a, b), d);
        end
    endtask

    task automatic test_reset_mid;
        int d;
        start_E = 1'b1; op_E = 3'd0; src_a_E = 32'd99; src_b_E = 32'd77; rd_E = 5'd25;
        @(posedge clk); #1;
        start_E = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (done !== 1'b0 || result !== 32'd0 || rd_out !== 5'd0 || stall_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: done=%b result=%h rd_out=%0d stall=%b expected all 0", done, result, rd_out, stall_req);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check_done_low("after_reset_idle");
        run_op(3'd7, 32'd1000, 32'd7, 5'd26, 32'd6, 33, d);
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_flush();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
